keypad_scanner: RTL and testbench
=================================

# keypad_scanner

- Scans a 4x4 matrix keypad by driving one column low at a time and sampling the rows.
- Debounces press and release, and reports each confirmed key as a 16-bit one-hot code.
- Sits between the keypad pins and the one-hot-to-hex decoder; `one_hot` is the decoder's input.
- `key_valid` marks each new press for the display-shift logic.

## Interface

Parameters:
- `SCAN_DIV`, default 1000: clock cycles each column is driven; must be >= 4.
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required to confirm a press or a release; must be >= 2.
- `REPEAT_CYCLES`, default 25000000: auto-repeat interval; used only with `KEYPAD_SCANNER_REPEAT_EN`.

Ports:
- `clk` input 1: system clock. Reset is synchronous, active-high.
- `reset` input 1: synchronous, active-high reset.
- `rows` input 4: keypad rows, active-low, asynchronous (pulled up externally).
- `cols` output 4: column drive, active-low, exactly one bit low at all times.
- `one_hot` output 16: last confirmed key; bit index = row*4 + col; all zero until the first press.
- `key_valid` output 1: one-cycle pulse when `one_hot` is updated by a confirmed press.
- `key_held` output 1: high while the confirmed key is held, through release debounce.

## Operation

Input path:
- `rows` passes through a 2-flop synchronizer to produce `rows_s`.
- `pressed` = ~`rows_s`.

States: SCAN, DEBOUNCE, HELD, RELEASE.

- **SCAN**
  - `cols` rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110, advancing every `SCAN_DIV` cycles.
  - `pressed` is sampled on the last cycle of each column dwell.
  - Exactly one bit of `pressed` set: latch that row and the current column, clear the debounce counter, go to DEBOUNCE. The column does not advance.
  - Zero bits or two or more bits set (ambiguous): advance the column, stay in SCAN.
- **DEBOUNCE**
  - Column frozen.
  - Each cycle, `pressed` equal to exactly the latched row bit increments the counter.
  - Any other value: return to SCAN, advance to the next column.
  - Counter reaches `DEBOUNCE_CYCLES`:
    - `one_hot` <= 1 << (row*4+col)
    - pulse `key_valid`
    - set `key_held`
    - go to HELD.
- **HELD**
  - Column frozen.
  - Presses on other keys or columns are ignored (single-key tracking).
  - Latched row bit deasserted: clear the counter, go to RELEASE.
- **RELEASE**
  - Latched row bit deasserted: increment the counter.
  - Latched row bit reasserted: return to HELD. No new `key_valid`, counter cleared.
  - Counter reaches `DEBOUNCE_CYCLES`: clear `key_held`, go to SCAN, resume rotation from the next column.
- `one_hot` retains the last key after release; only a new confirmed press changes it.

Counter widths:
- Use `$clog2` of the parameter + 1.
- Counters saturate, never wrap.

## Timing

Reset values:
- `cols` = 4'b1110
- `one_hot` = 16'h0000
- `key_valid` = 0
- `key_held` = 0
- state = SCAN
- all counters 0
- synchronizer flops = 4'b1111

Reset behaviour:
- Reset asserted mid-operation (any state) forces these values on the next edge.
- No `key_valid` is emitted by reset.

Latencies and pulses:
- Latency from stable `rows` change to `pressed`: 2 cycles.
- Press latency: from the sampling edge that detects the key, `key_valid` rises exactly `DEBOUNCE_CYCLES` cycles later, and `one_hot` changes on the same edge.
- `key_valid` is high for exactly one cycle per confirmed press.
- `key_valid` and `one_hot` are registered outputs; no combinational path from `rows`.
- `cols` is registered and changes only on column-advance edges.

Boundary conditions:
- Bounce during DEBOUNCE restarts scanning; it must not emit `key_valid`.
- Bounce during RELEASE returns to HELD; it must not emit `key_valid`.
- A second key pressed while the first is held produces nothing.
- If the first key then releases while the second remains, the second is detected on a later scan.

## Configuration

`KEYPAD_SCANNER_REPEAT_EN`:
- **Defined:**
  - In HELD, a repeat counter runs.
  - Every `REPEAT_CYCLES` cycles held, `key_valid` pulses again with `one_hot` unchanged.
  - The counter clears on entering HELD from DEBOUNCE and is held during RELEASE.
  - Return from RELEASE to HELD resumes without reset.
- **Undefined:**
  - No repeat logic is synthesized.
  - Exactly one `key_valid` per press.

## Test plan

Use `SCAN_DIV`=4, `DEBOUNCE_CYCLES`=8, `REPEAT_CYCLES`=20.

1. **Reset:** assert `reset` 3 cycles with `rows`=4'b1111.
   - Outputs at reset values (`cols`=1110, `one_hot`=0).
   - After release of reset, `cols` steps 1110 -> 1101 every 4 cycles.
2. **Clean press:** hold row 2 low only while col 1 is driven, then continuously.
   - Exactly one `key_valid` pulse, with `one_hot`=16'h0200 (bit 9).
   - `key_held`=1.
   - `cols` frozen at 1101.
3. **Bounce:** toggle row 0 every 3 cycles while col 3 is driven, for 40 cycles.
   - No `key_valid`.
   - `one_hot` unchanged.
   - Scan continues rotating.
4. **Release and re-press:**
   - Release the key from scenario 2 for 5 cycles, then reassert: `key_held` stays 1, no pulse.
   - Then release for 20 cycles: `key_held`=0 and rotation resumes, with `one_hot` still 16'h0200.
5. **Ambiguous / second key:**
   - Rows 0 and 3 both low on col 0: no detection.
   - While key (r1,c2) is held, press (r3,c0): no pulse, and `one_hot`=16'h0040 retained.
6. **Repeat, with the macro defined:**
   - Hold (r3,c3) for 70 cycles after confirmation.
   - `key_valid` pulses at +0, +20, +40, +60, with `one_hot`=16'h8000.
   - Without the macro: a single pulse.

Source files
------------

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with press/release debounce and one-hot key output.
// Optional auto-repeat of key_valid while held: define KEYPAD_SCANNER_REPEAT_EN.
module keypad_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  rows,
  output logic [3:0]  cols,
  output logic [15:0] one_hot,
  output logic        key_valid,
  output logic        key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV) + 1;
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES) + 1;

  localparam logic [1:0] ST_SCAN    = 2'd0;
  localparam logic [1:0] ST_DEB     = 2'd1;
  localparam logic [1:0] ST_HELD    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  if (SCAN_DIV < 4 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("keypad_scanner: invalid parameters");
  end

  logic [3:0]       sync_q, rows_s_q;
  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DEB_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]       col_q, col_d;
  logic [3:0]       cols_q, cols_d;
  logic [1:0]       row_q, row_d;
  logic [15:0]      one_hot_q, one_hot_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;

  logic [3:0] pressed;
  logic [1:0] pressed_row;
  logic       single;
  logic       advance;

`ifdef KEYPAD_SCANNER_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES) + 1;
  logic [REP_W-1:0] rep_q, rep_d;
`endif

  assign pressed = ~rows_s_q;
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  // Only a single active row is a usable key; two or more rows on one column is ambiguous.
  always_comb begin
    single      = 1'b1;
    pressed_row = 2'd0;
    case (pressed)
      4'b0001: pressed_row = 2'd0;
      4'b0010: pressed_row = 2'd1;
      4'b0100: pressed_row = 2'd2;
      4'b1000: pressed_row = 2'd3;
      default: single = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    col_d       = col_q;
    cols_d      = cols_q;
    row_d       = row_q;
    one_hot_d   = one_hot_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    advance     = 1'b0;
`ifdef KEYPAD_SCANNER_REPEAT_EN
    rep_d       = rep_q;
`endif

    case (state_q)
      ST_SCAN: begin
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
          if (single) begin
            row_d   = pressed_row;
            cnt_d   = '0;
            div_d   = '0;
            state_d = ST_DEB;
          end else begin
            advance = 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_DEB: begin
        if (pressed == (4'b0001 << row_q)) begin
          if (cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
            one_hot_d   = 16'h0001 << {row_q, col_q};
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
            cnt_d       = '0;
            state_d     = ST_HELD;
`ifdef KEYPAD_SCANNER_REPEAT_EN
            rep_d       = '0;
`endif
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          state_d = ST_SCAN;
          advance = 1'b1;
        end
      end
      ST_HELD: begin
        if (!pressed[row_q]) begin
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end else begin
`ifdef KEYPAD_SCANNER_REPEAT_EN
          if (rep_q == REP_W'(REPEAT_CYCLES - 1)) begin
            rep_d       = '0;
            key_valid_d = 1'b1;
          end else begin
            rep_d = rep_q + 1'b1;
          end
`endif
        end
      end
      default: begin
        // A reassertion during release debounce is bounce, not a new press.
        if (pressed[row_q]) begin
          cnt_d   = '0;
          state_d = ST_HELD;
        end else if (cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
          cnt_d      = '0;
          key_held_d = 1'b0;
          state_d    = ST_SCAN;
          advance    = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    endcase

    if (advance) begin
      col_d  = col_q + 2'd1;
      cols_d = {cols_q[2:0], cols_q[3]};
      div_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= 4'b1111;
      rows_s_q    <= 4'b1111;
      state_q     <= ST_SCAN;
      div_q       <= '0;
      cnt_q       <= '0;
      col_q       <= 2'd0;
      cols_q      <= 4'b1110;
      row_q       <= 2'd0;
      one_hot_q   <= 16'h0000;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEYPAD_SCANNER_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      sync_q      <= rows;
      rows_s_q    <= sync_q;
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      cols_q      <= cols_d;
      row_q       <= row_d;
      one_hot_q   <= one_hot_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
`ifdef KEYPAD_SCANNER_REPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

  assign cols      = cols_q;
  assign one_hot   = one_hot_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner against a timestamp-based keypad model.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 8;
  localparam int RP = 20;

  localparam int M_SCAN = 0;
  localparam int M_DEB  = 1;
  localparam int M_HELD = 2;
  localparam int M_REL  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [15:0] one_hot;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys = 16'h0000;

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  // Model state: edge count, mode, and timestamps of the last scan restart, detection and release.
  int e = 0;
  int m_mode = M_SCAN;
  int t_scan0 = 0;
  int c0 = 0;
  int t_det = 0;
  int t_rel = 0;
  int lr = 0;
  int lc = 0;
  int held_n = 0;
  logic [3:0]  hist[$];
  logic [15:0] m_one_hot = 16'h0000;
  logic        m_kv = 1'b0;
  logic        m_held = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [3:0] rows_from(input logic [15:0] k, input logic [3:0] c);
    logic [3:0] r;
    r = 4'hF;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (k[ri*4+ci] && !c[ci]) r[ri] = 1'b0;
    return r;
  endfunction

  assign rows = rows_from(keys, cols);

  keypad_scanner #(
    .SCAN_DIV(SD),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_CYCLES(RP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rows(rows),
    .cols(cols),
    .one_hot(one_hot),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  function automatic logic [3:0] exp_cols();
    int c;
    c = (m_mode == M_SCAN) ? (c0 + (e - t_scan0) / SD) % 4 : lc;
    return ~(4'b0001 << c);
  endfunction

  task automatic model_step(input logic [3:0] rows_now, input logic rst);
    logic [3:0] p;
    int cur;
    e++;
    if (rst) begin
      m_mode = M_SCAN; t_scan0 = e; c0 = 0; held_n = 0;
      hist = '{4'hF, 4'hF};
      m_one_hot = 16'h0000; m_kv = 1'b0; m_held = 1'b0;
      return;
    end
    p = ~hist[0];
    void'(hist.pop_front());
    hist.push_back(rows_now);
    m_kv = 1'b0;
    case (m_mode)
      M_SCAN: begin
        if ((e - t_scan0) % SD == 0 && $countones(p) == 1) begin
          cur = (c0 + (e - 1 - t_scan0) / SD) % 4;
          for (int i = 0; i < 4; i++) if (p[i]) lr = i;
          lc = cur; t_det = e; m_mode = M_DEB;
        end
      end
      M_DEB: begin
        if (p != (4'b0001 << lr)) begin
          m_mode = M_SCAN; c0 = (lc + 1) % 4; t_scan0 = e;
        end else if (e - t_det == DB) begin
          m_one_hot = 16'h0001 << (lr * 4 + lc);
          m_kv = 1'b1; m_held = 1'b1; held_n = 0; m_mode = M_HELD;
        end
      end
      M_HELD: begin
        if (!p[lr]) begin
          m_mode = M_REL; t_rel = e;
        end else begin
`ifdef KEYPAD_SCANNER_REPEAT_EN
          held_n++;
          if (held_n % RP == 0) m_kv = 1'b1;
`endif
        end
      end
      default: begin
        if (p[lr]) m_mode = M_HELD;
        else if (e - t_rel == DB) begin
          m_held = 1'b0; m_mode = M_SCAN; c0 = (lc + 1) % 4; t_scan0 = e;
        end
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h edge=%0d", tag, obs, exp_v, e);
    end
  endtask

  task automatic tick();
    logic [3:0] rn;
    rn = rows_from(keys, exp_cols());
    @(posedge clk);
    model_step(rn, reset);
    @(negedge clk);
    chk("cols", {28'd0, cols}, {28'd0, exp_cols()});
    chk("one_hot", {16'd0, one_hot}, {16'd0, m_one_hot});
    chk("key_valid", {31'd0, key_valid}, {31'd0, m_kv});
    chk("key_held", {31'd0, key_held}, {31'd0, m_held});
    if (key_valid === 1'b1) pulses++;
  endtask

  task automatic wait_pulse(input string tag, input int budget);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (!got && n < budget) begin
      tick();
      n++;
      if (key_valid === 1'b1) got = 1'b1;
    end
    chk(tag, {31'd0, got}, 32'd1);
  endtask

  initial begin
    int changes;
    logic [3:0] last_cols;
    int kind;
    int dur;

    // Reset and first column step
    reset = 1'b1; keys = 16'h0000;
    repeat (3) tick();
    chk("reset_cols", {28'd0, cols}, 32'hE);
    chk("reset_one_hot", {16'd0, one_hot}, 32'h0);
    reset = 1'b0;
    repeat (3) tick();
    chk("dwell_cols", {28'd0, cols}, 32'hE);
    tick();
    chk("step_cols", {28'd0, cols}, 32'hD);

    // Clean press of (r2,c1)
    keys = 16'h0200;
    pulses = 0;
    wait_pulse("press_r2c1", 60);
    chk("press_one_hot", {16'd0, one_hot}, 32'h0200);
    repeat (15) tick();
    chk("press_single_pulse", pulses, 1);
    chk("press_held", {31'd0, key_held}, 32'd1);
    chk("press_cols_frozen", {28'd0, cols}, 32'hD);

    // Release bounce then real release
    pulses = 0;
    keys = 16'h0000;
    repeat (5) tick();
    keys = 16'h0200;
    repeat (6) tick();
    chk("rebounce_held", {31'd0, key_held}, 32'd1);
`ifndef KEYPAD_SCANNER_REPEAT_EN
    chk("rebounce_no_pulse", pulses, 0);
`endif
    keys = 16'h0000;
    changes = 0;
    last_cols = cols;
    repeat (20) begin
      tick();
      if (cols !== last_cols) changes++;
      last_cols = cols;
    end
    chk("release_held", {31'd0, key_held}, 32'd0);
    chk("release_one_hot", {16'd0, one_hot}, 32'h0200);
    chk("release_rotates", {31'd0, changes > 0}, 32'd1);

    // Bouncing (r0,c3)
    pulses = 0;
    changes = 0;
    last_cols = cols;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) keys = keys ^ 16'h0008;
      tick();
      if (cols !== last_cols) changes++;
      last_cols = cols;
    end
    chk("bounce_no_pulse", pulses, 0);
    chk("bounce_one_hot", {16'd0, one_hot}, 32'h0200);
    chk("bounce_rotates", {31'd0, changes > 0}, 32'd1);
    keys = 16'h0000;
    repeat (10) tick();

    // Ambiguous rows 0 and 3 on column 0
    pulses = 0;
    keys = 16'h1001;
    repeat (40) tick();
    chk("ambiguous_no_pulse", pulses, 0);
    keys = 16'h0000;
    repeat (4) tick();

    // Second key while (r1,c2) held, then first released
    keys = 16'h0040;
    wait_pulse("press_r1c2", 60);
    chk("r1c2_one_hot", {16'd0, one_hot}, 32'h0040);
    pulses = 0;
    keys = 16'h1040;
    repeat (15) tick();
    chk("second_key_no_pulse", pulses, 0);
    chk("second_key_retained", {16'd0, one_hot}, 32'h0040);
    keys = 16'h1000;
    wait_pulse("second_key_detect", 80);
    chk("second_key_one_hot", {16'd0, one_hot}, 32'h1000);
    keys = 16'h0000;
    repeat (20) tick();

    // Long hold of (r3,c3)
    keys = 16'h8000;
    wait_pulse("press_r3c3", 60);
    pulses = 1;
    repeat (69) tick();
`ifdef KEYPAD_SCANNER_REPEAT_EN
    chk("repeat_pulses", pulses, 4);
`else
    chk("repeat_pulses", pulses, 1);
`endif
    chk("repeat_one_hot", {16'd0, one_hot}, 32'h8000);
    keys = 16'h0000;
    repeat (15) tick();

    // Reset while a key is held
    keys = 16'h0020;
    wait_pulse("press_r1c1", 60);
    repeat (3) tick();
    reset = 1'b1; keys = 16'h0000;
    tick();
    chk("midreset_held", {31'd0, key_held}, 32'd0);
    chk("midreset_one_hot", {16'd0, one_hot}, 32'h0);
    chk("midreset_cols", {28'd0, cols}, 32'hE);
    chk("midreset_valid", {31'd0, key_valid}, 32'd0);
    reset = 1'b0;
    repeat (10) tick();

    // Randomized key activity against the model
    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(0, 5);
      dur = $urandom_range(3, 50);
      case (kind)
        0: keys = 16'h0000;
        4: keys = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
        5: keys = 16'h0000;
        default: keys = 16'h0001 << $urandom_range(0, 15);
      endcase
      for (int j = 0; j < dur; j++) begin
        if (kind == 5 && $urandom_range(0, 2) == 0) keys = keys ^ (16'h0001 << $urandom_range(0, 15));
        tick();
      end
    end
    keys = 16'h0000;
    repeat (30) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
